// File: rtl/obstacle_pkg.sv
// Shared playfield constants, default slot geometry and the scheduler state encoding.
package obstacle_pkg;

   localparam int unsigned LEFT = 155;
   localparam int unsigned BG_W = 330;
   localparam int unsigned BG_H = 480;

   localparam int unsigned SLOTS_D   = 5;
   localparam int unsigned PIPE_W_D  = 40;
   localparam int unsigned SPACING_D = 80;
   localparam int unsigned GAP_H_D   = 120;
   localparam int unsigned COIN_SZ_D = 20;

   localparam int unsigned TOP_INIT = 160;
   localparam int unsigned TOP_MIN  = 40;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      SCROLL,
      CHECK,
      OVER
   } state_e;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) supplying recycle gap heights.
module lfsr16
   import obstacle_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = {state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5], state_q[15:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LFSR_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Scrolls, recycles and collision-checks five pipe/coin slots once per frame tick.
// Coin logic is built when OBSTACLE_COINS_EN is defined; otherwise score counts passed pipes.
module obstacle_scheduler
   import obstacle_pkg::*;
#(
   parameter int unsigned SLOTS   = SLOTS_D,
   parameter int unsigned PIPE_W  = PIPE_W_D,
   parameter int unsigned SPACING = SPACING_D,
   parameter int unsigned GAP_H   = GAP_H_D,
   parameter int unsigned COIN_SZ = COIN_SZ_D
)
(
   input  logic        clk_100MHz,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start,
   input  logic [2:0]  speed,
   input  logic [9:0]  Bird_X_L,
   input  logic [9:0]  Bird_X_R,
   input  logic [9:0]  Bird_Y_T,
   input  logic [9:0]  Bird_Y_B,
   output logic [49:0] X_Edge_L,
   output logic [49:0] X_Edge_R,
   output logic [49:0] Y_Edge_Top,
   output logic [49:0] Y_Edge_Bottom,
   output logic [49:0] X_Coin_L,
   output logic [49:0] X_Coin_R,
   output logic [49:0] Y_Coin,
   output logic [4:0]  Show_Coin,
   output logic        busy,
   output logic        collide,
   output logic        game_over,
   output logic [7:0]  score,
   output logic        overrun
);

   state_e      state_q, state_d;
   logic [2:0]  k_q, k_d;
   logic [9:0]  px_q  [SLOTS];
   logic [9:0]  px_d  [SLOTS];
   logic [9:0]  top_q [SLOTS];
   logic [9:0]  top_d [SLOTS];
   logic [9:0]  x_r   [SLOTS];
   logic [9:0]  bot   [SLOTS];
   logic        busy_q, busy_d;
   logic        collide_q, collide_d;
   logic        game_over_q, game_over_d;
   logic [7:0]  score_q, score_d;
   logic        overrun_q, overrun_d;
   logic        hit_q, hit_d;
   logic        load_init;
   logic        recycle;
   logic        pipe_hit;
   logic        floor_hit;
   logic        bonus;
   logic [15:0] lfsr;
   logic        lfsr_unused;

`ifdef OBSTACLE_COINS_EN
   localparam int unsigned COIN_XL_OFS = (PIPE_W - COIN_SZ) / 2;
   localparam int unsigned COIN_XR_OFS = COIN_XL_OFS + COIN_SZ - 1;
   localparam int unsigned COIN_Y_OFS  = 50;
   logic [SLOTS-1:0] coin_q, coin_d;
   logic [9:0]       cxl [SLOTS];
   logic [9:0]       cxr [SLOTS];
   logic [9:0]       cy  [SLOTS];
`else
   logic [SLOTS-1:0] passed_q, passed_d;
   logic [9:0]       coin_sz_unused;
   assign coin_sz_unused = 10'(COIN_SZ);
`endif

   if (SLOTS != 5 || COIN_SZ > PIPE_W) begin : g_bad_geometry
      $error("obstacle_scheduler needs SLOTS == 5 and COIN_SZ <= PIPE_W");
   end

   lfsr16 u_lfsr (
      .clk   (clk_100MHz),
      .rst   (rst),
      .state (lfsr)
   );
   assign lfsr_unused = ^lfsr[15:8];

   // Per-slot geometry derived from the px/top registers.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         x_r[i] = px_q[i] + 10'(PIPE_W - 1);
         bot[i] = top_q[i] + 10'(GAP_H);
`ifdef OBSTACLE_COINS_EN
         cxl[i] = px_q[i] + 10'(COIN_XL_OFS);
         cxr[i] = px_q[i] + 10'(COIN_XR_OFS);
         cy[i]  = top_q[i] + 10'(COIN_Y_OFS);
`endif
      end
   end

   // Evaluation of the slot currently addressed by k.
   always_comb begin
      recycle   = (px_q[k_q] + 10'(PIPE_W)) <= 10'(LEFT);
      floor_hit = Bird_Y_B >= 10'(BG_H - 1);
      pipe_hit  = (Bird_X_R >= px_q[k_q]) && (Bird_X_L <= x_r[k_q]) &&
                  ((Bird_Y_T <= top_q[k_q]) || (Bird_Y_B >= bot[k_q]));
`ifdef OBSTACLE_COINS_EN
      bonus     = coin_q[k_q] &&
                  (Bird_X_R >= cxl[k_q]) && (Bird_X_L <= cxr[k_q]) &&
                  (Bird_Y_B >= cy[k_q]) && (Bird_Y_T <= cy[k_q] + 10'(COIN_SZ - 1));
`else
      bonus     = !passed_q[k_q] && (x_r[k_q] < Bird_X_L);
`endif
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      px_d      = px_q;
      top_d     = top_q;
      collide_d = 1'b0;
      score_d   = score_q;
      overrun_d = overrun_q;
      hit_d     = hit_q;
      load_init = 1'b0;
`ifdef OBSTACLE_COINS_EN
      coin_d    = coin_q;
`else
      passed_d  = passed_q;
`endif

      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               load_init = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (frame_tick) begin
               state_d = SCROLL;
               k_d     = '0;
               hit_d   = 1'b0;
            end
         end
         SCROLL: begin
            if (frame_tick) overrun_d = 1'b1;
            if (recycle) begin
               px_d[k_q]  = px_q[k_q] + 10'(SLOTS * SPACING);
               top_d[k_q] = 10'(TOP_MIN) + {2'b00, lfsr[7:0]};
`ifdef OBSTACLE_COINS_EN
               coin_d[k_q]   = 1'b1;
`else
               passed_d[k_q] = 1'b0;
`endif
            end else begin
               px_d[k_q] = px_q[k_q] - {7'd0, speed};
            end
            if (k_q == 3'(SLOTS - 1)) begin
               state_d = CHECK;
               k_d     = '0;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         CHECK: begin
            if (frame_tick) overrun_d = 1'b1;
            hit_d = hit_q | pipe_hit | floor_hit;
            if (bonus) begin
`ifdef OBSTACLE_COINS_EN
               coin_d[k_q]   = 1'b0;
`else
               passed_d[k_q] = 1'b1;
`endif
               if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end
            if (k_q == 3'(SLOTS - 1)) begin
               k_d = '0;
               if (hit_d) begin
                  collide_d = 1'b1;
                  state_d   = OVER;
               end else begin
                  state_d = RUN;
               end
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_init) begin
         for (int i = 0; i < SLOTS; i++) begin
            px_d[i]  = 10'(LEFT + BG_W + i * SPACING);
            top_d[i] = 10'(TOP_INIT);
         end
         score_d   = '0;
         overrun_d = 1'b0;
`ifdef OBSTACLE_COINS_EN
         coin_d    = '1;
`else
         passed_d  = '0;
`endif
      end

      busy_d      = (state_d == SCROLL) || (state_d == CHECK);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            px_q[i]  <= 10'(LEFT + BG_W + i * SPACING);
            top_q[i] <= 10'(TOP_INIT);
         end
         busy_q      <= 1'b0;
         collide_q   <= 1'b0;
         game_over_q <= 1'b0;
         score_q     <= '0;
         overrun_q   <= 1'b0;
         hit_q       <= 1'b0;
`ifdef OBSTACLE_COINS_EN
         coin_q      <= '0;
`else
         passed_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         px_q        <= px_d;
         top_q       <= top_d;
         busy_q      <= busy_d;
         collide_q   <= collide_d;
         game_over_q <= game_over_d;
         score_q     <= score_d;
         overrun_q   <= overrun_d;
         hit_q       <= hit_d;
`ifdef OBSTACLE_COINS_EN
         coin_q      <= coin_d;
`else
         passed_q    <= passed_d;
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         X_Edge_L[10*i +: 10]      = px_q[i];
         X_Edge_R[10*i +: 10]      = x_r[i];
         Y_Edge_Top[10*i +: 10]    = top_q[i];
         Y_Edge_Bottom[10*i +: 10] = bot[i];
`ifdef OBSTACLE_COINS_EN
         X_Coin_L[10*i +: 10]      = cxl[i];
         X_Coin_R[10*i +: 10]      = cxr[i];
         Y_Coin[10*i +: 10]        = cy[i];
`else
         X_Coin_L[10*i +: 10]      = '0;
         X_Coin_R[10*i +: 10]      = '0;
         Y_Coin[10*i +: 10]        = '0;
`endif
      end
   end

`ifdef OBSTACLE_COINS_EN
   assign Show_Coin = coin_q;
`else
   assign Show_Coin = '0;
`endif
   assign busy      = busy_q;
   assign collide   = collide_q;
   assign game_over = game_over_q;
   assign score     = score_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: reset, scroll, recycle, scoring, collisions, overrun.
module tb_obstacle_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        start;
   logic [2:0]  speed;
   logic [9:0]  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
   logic [49:0] X_Edge_L, X_Edge_R, Y_Edge_Top, Y_Edge_Bottom;
   logic [49:0] X_Coin_L, X_Coin_R, Y_Coin;
   logic [4:0]  Show_Coin;
   logic        busy, collide, game_over, overrun;
   logic [7:0]  score;

   int errors = 0;
   int checks = 0;
   int nb, nc, ca, nc_tot;
   logic [9:0] t0;

   always #5 clk = ~clk;

   obstacle_scheduler dut (
      .clk_100MHz    (clk),
      .rst           (rst),
      .frame_tick    (frame_tick),
      .start         (start),
      .speed         (speed),
      .Bird_X_L      (Bird_X_L),
      .Bird_X_R      (Bird_X_R),
      .Bird_Y_T      (Bird_Y_T),
      .Bird_Y_B      (Bird_Y_B),
      .X_Edge_L      (X_Edge_L),
      .X_Edge_R      (X_Edge_R),
      .Y_Edge_Top    (Y_Edge_Top),
      .Y_Edge_Bottom (Y_Edge_Bottom),
      .X_Coin_L      (X_Coin_L),
      .X_Coin_R      (X_Coin_R),
      .Y_Coin        (Y_Coin),
      .Show_Coin     (Show_Coin),
      .busy          (busy),
      .collide       (collide),
      .game_over     (game_over),
      .score         (score),
      .overrun       (overrun)
   );

   function automatic logic [9:0] sl(input logic [49:0] v, input int i);
      return v[10*i +: 10];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // One frame tick, then watch 16 cycles; index 0 is the cycle after the tick was sampled.
   task automatic run_frame(output int n_busy, output int n_col, output int col_at);
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      n_busy = 0; n_col = 0; col_at = -1;
      for (int i = 0; i < 16; i++) begin
         if (busy) n_busy++;
         if (collide) begin
            n_col++;
            if (col_at < 0) col_at = i;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; frame_tick = 1'b0; start = 1'b0; speed = 3'd0;
      Bird_X_L = 10'd0; Bird_X_R = 10'd5; Bird_Y_T = 10'd200; Bird_Y_B = 10'd220;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_px0", sl(X_Edge_L, 0), 485);
      check("rst_px4", sl(X_Edge_L, 4), 805);
      check("rst_show", Show_Coin, 0);
      check("rst_busy", busy, 0);
      check("rst_gover", game_over, 0);
      check("rst_score", score, 0);
      check("rst_overrun", overrun, 0);

      do_start();
`ifdef OBSTACLE_COINS_EN
      check("start_show", Show_Coin, 5'b11111);
`else
      check("start_show", Show_Coin, 5'b00000);
`endif
      check("start_gover", game_over, 0);
      check("start_xr0", sl(X_Edge_R, 0), 524);
      check("start_bot1", sl(Y_Edge_Bottom, 1), 280);

      speed = 3'd4;
      run_frame(nb, nc, ca);
      check("f1_busy_cycles", nb, 10);
      check("f1_collide", nc, 0);
      check("f1_px0", sl(X_Edge_L, 0), 481);
      check("f1_px4", sl(X_Edge_L, 4), 801);
`ifdef OBSTACLE_COINS_EN
      check("f1_coin_xl0", sl(X_Coin_L, 0), 491);
      check("f1_coin_y0", sl(Y_Coin, 0), 210);
`else
      check("f1_coin_xl0", sl(X_Coin_L, 0), 0);
`endif
      check("f1_overrun", overrun, 0);

      // Second tick lands in SCROLL and must be dropped.
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      repeat (14) @(negedge clk);
      check("ovr_flag", overrun, 1);
      check("ovr_px0_once", sl(X_Edge_L, 0), 477);
      check("ovr_busy_done", busy, 0);

      speed = 3'd7;
      nc_tot = 0;
      repeat (52) begin
         run_frame(nb, nc, ca);
         nc_tot += nc;
      end
      check("scroll_collides", nc_tot, 0);
      check("scroll_px0", sl(X_Edge_L, 0), 113);
      check("scroll_px1", sl(X_Edge_L, 1), 193);

      run_frame(nb, nc, ca);
      t0 = sl(Y_Edge_Top, 0);
      check("recyc_px0", sl(X_Edge_L, 0), 513);
      check("recyc_xr0", sl(X_Edge_R, 0), 552);
      check("recyc_top_range", (t0 >= 10'd40 && t0 <= 10'd295), 1);
      check("recyc_px1", sl(X_Edge_L, 1), 186);
`ifdef OBSTACLE_COINS_EN
      check("recyc_show0", Show_Coin[0], 1);
`endif

      // Bird inside pipe 2's gap on its coin; pipe 1 is already behind it.
      speed = 3'd0;
      Bird_X_L = 10'd280; Bird_X_R = 10'd290; Bird_Y_T = 10'd215; Bird_Y_B = 10'd225;
      run_frame(nb, nc, ca);
      check("coin_px2", sl(X_Edge_L, 2), 266);
      check("coin_collide", nc, 0);
      check("coin_score", score, 1);
`ifdef OBSTACLE_COINS_EN
      check("coin_show", Show_Coin, 5'b11011);
`else
      check("coin_show", Show_Coin, 5'b00000);
`endif
      run_frame(nb, nc, ca);
      check("coin_score_once", score, 1);

      Bird_X_L = 10'd190; Bird_X_R = 10'd200; Bird_Y_T = 10'd20; Bird_Y_B = 10'd40;
      run_frame(nb, nc, ca);
      check("hit_collides", nc, 1);
      check("hit_cycle", ca, 10);
      check("hit_busy_cycles", nb, 10);
      check("hit_gover", game_over, 1);
      check("hit_score", score, 1);

      run_frame(nb, nc, ca);
      check("over_busy", nb, 0);
      check("over_collide", nc, 0);
      check("over_px1", sl(X_Edge_L, 1), 186);
      check("over_gover", game_over, 1);

      do_start();
      check("restart_gover", game_over, 0);
      check("restart_score", score, 0);
      check("restart_overrun", overrun, 0);
      check("restart_px0", sl(X_Edge_L, 0), 485);

      Bird_X_L = 10'd0; Bird_X_R = 10'd5; Bird_Y_T = 10'd460; Bird_Y_B = 10'd479;
      run_frame(nb, nc, ca);
      check("floor_collide", nc, 1);
      check("floor_gover", game_over, 1);

      Bird_Y_T = 10'd200; Bird_Y_B = 10'd220;
      do_start();
      speed = 3'd3;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
      check("midrst_busy_before", busy, 1);
      check("midrst_px0_before", sl(X_Edge_L, 0), 482);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_px0", sl(X_Edge_L, 0), 485);
      check("midrst_gover", game_over, 0);
      check("midrst_show", Show_Coin, 0);
      @(negedge clk) rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
